// File: rtl/calc_sequencer.sv
// calc_sequencer: sequences operand entry, ALU issue/wait over start/done, and result display
module calc_sequencer #(
  parameter int WIDTH   = 6,
  parameter int IN_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             confirm,
  input  logic             clear,
  input  logic [1:0]       op_sel,
  input  logic [IN_W-1:0]  operand_in,
  output logic             alu_start,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  output logic [WIDTH-1:0] disp_value,
  output logic             busy,
  output logic             err
);
  typedef enum logic [3:0] {IDLE, OP1, OP1_WR, OP2, OP2_WR, ISSUE, WAIT, SHOW, DRAIN} state_t;
  state_t state;
  logic [7:0] cnt;
  logic [WIDTH-1:0] ext;
  logic tmo;
  assign ext = {{(WIDTH-IN_W){1'b0}}, operand_in};
  assign tmo = cnt == 8'(TIMEOUT - 1);
  // Sequencer FSM; alu_a/alu_b/alu_op are the latched operands and stay put while the ALU works
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_start  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      disp_value <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      if (clear) begin
        state      <= (state == ISSUE || state == WAIT) ? DRAIN : OP1;
        busy       <= state == ISSUE || state == WAIT;
        cnt        <= '0;
        err        <= 1'b0;
        disp_value <= '0;
        alu_a      <= '0;
        alu_b      <= '0;
        alu_op     <= '0;
      end else begin
        case (state)
          IDLE: state <= OP1;
          OP1: begin
            disp_value <= ext;
            if (confirm) begin
              alu_a <= ext;
              err   <= 1'b0;
              state <= OP1_WR;
            end
          end
          OP1_WR: if (!confirm) state <= OP2;
          OP2: begin
            disp_value <= ext;
            if (confirm) begin
              alu_b  <= ext;
              alu_op <= op_sel;
              state  <= OP2_WR;
            end
          end
          OP2_WR: if (!confirm) begin
            if (alu_op == 2'b11) begin
              err        <= 1'b1;
              disp_value <= '0;
              state      <= SHOW;
            end else begin
              alu_start <= 1'b1;
              busy      <= 1'b1;
              state     <= ISSUE;
            end
          end
          ISSUE: begin
            cnt   <= '0;
            state <= WAIT;
          end
          WAIT: begin
            if (alu_done) begin
              disp_value <= alu_result;
              err        <= alu_ovf;
              busy       <= 1'b0;
              state      <= SHOW;
            end else if (tmo) begin
              disp_value <= '0;
              err        <= 1'b1;
              busy       <= 1'b0;
              state      <= SHOW;
            end else cnt <= cnt + 8'd1;
          end
          SHOW: if (confirm) begin
            alu_a <= err ? '0 : disp_value;
            err   <= 1'b0;
            state <= OP1_WR;
          end
          DRAIN: begin
            if (alu_done || tmo) begin
              busy  <= 1'b0;
              state <= OP1;
            end else cnt <= cnt + 8'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed and randomized checks of calc_sequencer against a behavioural ALU/sequencer model
module tb_calc_sequencer;
  localparam int W  = 6;
  localparam int IW = 4;
  localparam int T  = 15;
  logic clk = 1'b0, reset = 1'b1, confirm = 1'b0, clear = 1'b0;
  logic [1:0] op_sel = '0;
  logic [IW-1:0] operand_in = '0;
  logic alu_done = 1'b0, alu_ovf = 1'b0;
  logic [W-1:0] alu_result = '0;
  logic alu_start, busy, err;
  logic [1:0] alu_op;
  logic [W-1:0] alu_a, alu_b, disp_value;
  logic [W:0] alu_r;
  int checks = 0, failures = 0, starts = 0, alu_lat = 3;
  bit alu_en = 1'b1;
  logic [W-1:0] m_res = '0, exp_a = '0;
  bit m_err = 1'b0;

  calc_sequencer #(.WIDTH(W), .IN_W(IW), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .confirm(confirm), .clear(clear), .op_sel(op_sel),
    .operand_in(operand_in), .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf),
    .disp_value(disp_value), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] alu_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, r;
    logic [W-1:0] res;
    sa = $signed(a);
    sb = $signed(b);
    r = op == 2'd0 ? sa + sb : op == 2'd1 ? sa - sb : sa * sb;
    res = r[W-1:0];
    return {(r < -(1 << (W-1)) || r > (1 << (W-1)) - 1), res};
  endfunction

  // Behavioural ALU: answers each start pulse after alu_lat cycles unless disabled
  always begin
    @(posedge clk);
    #1;
    if (alu_start) begin
      starts++;
      if (alu_en) begin
        alu_r = alu_model(alu_op, alu_a, alu_b);
        repeat (alu_lat) @(posedge clk);
        #1;
        alu_done = 1'b1;
        {alu_ovf, alu_result} = alu_r;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        alu_ovf = 1'b0;
        alu_result = '0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enter_fresh(input logic [IW-1:0] a);
    clear = 1'b1;
    step();
    clear = 1'b0;
    operand_in = a;
    step();
    chk("op1_disp", disp_value, W'(a));
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    step();
    exp_a = W'(a);
  endtask

  task automatic enter_chain();
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    step();
    exp_a = m_err ? '0 : m_res;
  endtask

  task automatic do_issue(input logic [IW-1:0] b, input logic [1:0] op, input int lat);
    int n, s0;
    logic [W:0] r;
    alu_lat = lat;
    alu_en = 1'b1;
    s0 = starts;
    chk("op1_latched", alu_a, exp_a);
    operand_in = b;
    op_sel = op;
    step();
    chk("op2_disp", disp_value, W'(b));
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    step();
    if (op == 2'b11) begin
      chk("rsv_start", alu_start, 0);
      chk("rsv_err", err, 1);
      chk("rsv_disp", disp_value, 0);
      chk("rsv_busy", busy, 0);
      m_err = 1'b1;
      m_res = '0;
    end else begin
      chk("start", alu_start, 1);
      chk("issue_a", alu_a, exp_a);
      chk("issue_b", alu_b, W'(b));
      chk("issue_op", alu_op, op);
      chk("issue_busy", busy, 1);
      n = 0;
      while (busy && n < 40) begin
        step();
        n++;
      end
      chk("done_latency", n, lat + 1);
      r = alu_model(op, exp_a, W'(b));
      chk("result", disp_value, r[W-1:0]);
      chk("ovf_err", err, r[W]);
      m_err = r[W];
      m_res = r[W-1:0];
    end
    step(2);
    chk("start_count", starts, s0 + (op != 2'b11 ? 1 : 0));
  endtask

  initial begin
    int s0, n;
    step(2);
    chk("reset_outs", {alu_start, alu_op, alu_a, alu_b, disp_value, busy, err}, 0);
    reset = 1'b0;
    step();
    enter_fresh(4'd3);
    do_issue(4'd5, 2'b00, 3);
    chk("add_8", disp_value, 8);
    enter_chain();
    do_issue(4'd4, 2'b00, 2);
    chk("chain_12", disp_value, 12);
    enter_fresh(4'd2);
    do_issue(4'd7, 2'b01, 1);
    chk("sub_neg5", disp_value, 6'b111011);
    enter_fresh(4'd5);
    do_issue(4'd6, 2'b11, 1);
    enter_fresh(4'd1);
    alu_en = 1'b0;
    operand_in = 4'd2;
    op_sel = 2'b00;
    step();
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    step();
    chk("to_start", alu_start, 1);
    step(T);
    chk("to_err_early", err, 0);
    chk("to_busy_early", busy, 1);
    step();
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_disp", disp_value, 0);
    enter_fresh(4'd6);
    operand_in = 4'd3;
    step();
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    step();
    chk("rst_start", alu_start, 1);
    step(3);
    reset = 1'b1;
    #1;
    chk("reset_mid", {alu_start, alu_op, alu_a, alu_b, disp_value, busy, err}, 0);
    s0 = starts;
    step(3);
    reset = 1'b0;
    alu_en = 1'b1;
    operand_in = 4'd7;
    step(3);
    chk("rst_no_start", starts, s0);
    chk("rst_op1_disp", disp_value, 7);
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    step();
    alu_lat = 6;
    operand_in = 4'd3;
    step();
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    step();
    chk("drain_start", alu_start, 1);
    step(2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("drain_busy", busy, 1);
    chk("drain_disp", disp_value, 0);
    chk("drain_err", err, 0);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("drain_exit", busy, 0);
    chk("drain_disp_after", disp_value, 0);
    operand_in = 4'd9;
    confirm = 1'b1;
    step();
    operand_in = 4'd2;
    step(3);
    chk("hold_once", alu_a, 9);
    confirm = 1'b0;
    step();
    exp_a = 6'd9;
    do_issue(4'd1, 2'b00, 2);
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 0) enter_fresh(IW'($urandom_range(0, 15)));
      else enter_chain();
      do_issue(IW'($urandom_range(0, 15)), $urandom_range(0, 9) == 0 ? 2'b11 : 2'($urandom_range(0, 2)),
               $urandom_range(1, 5));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
